// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_e;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/hazard_stall_counter.sv
// Saturating event counter used to count stalled fetch cycles.
module hazard_stall_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: step by one while enabled, pinned at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage pipeline: load-use bubbles, branch
// flushes, MUL/DIV launch/wait and data-memory wait freezes.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_uses_rs1_i,
   input  logic                  id_uses_rs2_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_is_muldiv_i,
   input  logic                  md_done_i,
   input  logic                  branch_taken_i,
   input  logic                  mem_req_i,
   input  logic                  mem_ready_i,
   output logic                  md_start_o,
   output logic                  stall_if_o,
   output logic                  stall_id_o,
   output logic                  stall_ex_o,
   output logic                  stall_mem_o,
   output logic                  flush_id_o,
   output logic                  flush_ex_o,
   output logic                  flush_mem_o,
   output logic                  ignore_fwd_ex_o,
   output logic [CNT_W-1:0]      stall_cycles_o
);

   state_e state_q, state_d;
   state_e ret_q, ret_d;
   state_e eff_state_s;
   logic   md_pend_q, md_pend_d;
   logic   ign_q, ign_d;
   logic   mem_wait_s, load_use_s;
   logic   md_start_s, stall_if_s, stall_id_s, stall_ex_s, stall_mem_s;
   logic   flush_id_s, flush_ex_s, flush_mem_s;

   // Hazard decode and next-state selection; a leaving freeze acts as its saved state.
   always_comb begin
      md_start_s  = 1'b0;
      stall_if_s  = 1'b0;
      stall_id_s  = 1'b0;
      stall_ex_s  = 1'b0;
      stall_mem_s = 1'b0;
      flush_id_s  = 1'b0;
      flush_ex_s  = 1'b0;
      flush_mem_s = 1'b0;
      state_d     = state_q;
      ret_d       = ret_q;
      md_pend_d   = md_pend_q;

      eff_state_s = (state_q == MEM_BUSY) ? ret_q : state_q;
      mem_wait_s  = mem_req_i & ~mem_ready_i;
      load_use_s  = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

      if (mem_wait_s) begin
         stall_if_s  = 1'b1;
         stall_id_s  = 1'b1;
         stall_ex_s  = 1'b1;
         stall_mem_s = 1'b1;
         state_d     = MEM_BUSY;
         ret_d       = eff_state_s;
         // A completion pulse during the freeze must not be lost.
         if ((eff_state_s == MD_BUSY) && md_done_i) begin
            md_pend_d = 1'b1;
         end else begin
            md_pend_d = md_pend_q;
         end
      end else begin
         case (eff_state_s)
            MD_BUSY: begin
               if (md_done_i || md_pend_q) begin
                  state_d   = RUN;
                  md_pend_d = 1'b0;
               end else begin
                  stall_if_s  = 1'b1;
                  stall_id_s  = 1'b1;
                  stall_ex_s  = 1'b1;
                  flush_mem_s = 1'b1;
                  state_d     = MD_BUSY;
               end
            end
            default: begin
               state_d = RUN;
               if (ex_is_muldiv_i && !md_pend_q) begin
                  md_start_s  = 1'b1;
                  stall_if_s  = 1'b1;
                  stall_id_s  = 1'b1;
                  stall_ex_s  = 1'b1;
                  flush_mem_s = 1'b1;
                  state_d     = MD_BUSY;
               end else if (branch_taken_i) begin
                  flush_id_s = 1'b1;
                  flush_ex_s = 1'b1;
               end else if (load_use_s) begin
                  stall_if_s = 1'b1;
                  stall_id_s = 1'b1;
                  flush_ex_s = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         endcase
      end

      ign_d = stall_ex_s ? ign_q : flush_ex_s;
   end

   // Controller state, saved return state, pending completion and bubble tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         ret_q     <= RUN;
         md_pend_q <= 1'b0;
         ign_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         md_pend_q <= md_pend_d;
         ign_q     <= ign_d;
      end
   end

   // Held low while reset is asserted so nothing leaks from live inputs.
   assign md_start_o      = md_start_s  & ~rst;
   assign stall_if_o      = stall_if_s  & ~rst;
   assign stall_id_o      = stall_id_s  & ~rst;
   assign stall_ex_o      = stall_ex_s  & ~rst;
   assign stall_mem_o     = stall_mem_s & ~rst;
   assign flush_id_o      = flush_id_s  & ~rst;
   assign flush_ex_o      = flush_ex_s  & ~rst;
   assign flush_mem_o     = flush_mem_s & ~rst;
   assign ignore_fwd_ex_o = ign_q;

   hazard_stall_counter #(
      .CNT_W (CNT_W)
   ) u_stall_counter (
      .clk   (clk),
      .rst   (rst),
      .en_i  (stall_if_s),
      .cnt_o (stall_cycles_o)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (CNT_W=4 to reach saturation).
module tb_pipeline_hazard_ctrl;

   localparam int RW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_muldiv;
   logic          md_done, branch_taken, mem_req, mem_ready;
   logic          md_start, stall_if, stall_id, stall_ex, stall_mem;
   logic          flush_id, flush_ex, flush_mem, ignore_fwd_ex;
   logic [CW-1:0] stall_cycles;

   int tests = 0;
   int fails = 0;
   int cnt_exp = 0;

   // bit order: md_start stall_if stall_id stall_ex stall_mem flush_id flush_ex flush_mem
   localparam logic [7:0] O_IDLE  = 8'b0000_0000;
   localparam logic [7:0] O_LU    = 8'b0110_0010;
   localparam logic [7:0] O_BR    = 8'b0000_0110;
   localparam logic [7:0] O_START = 8'b1111_0001;
   localparam logic [7:0] O_MDW   = 8'b0111_0001;
   localparam logic [7:0] O_FRZ   = 8'b0111_1000;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1_i        (id_rs1),
      .id_rs2_i        (id_rs2),
      .id_uses_rs1_i   (id_uses_rs1),
      .id_uses_rs2_i   (id_uses_rs2),
      .ex_mem_read_i   (ex_mem_read),
      .ex_rd_i         (ex_rd),
      .ex_is_muldiv_i  (ex_is_muldiv),
      .md_done_i       (md_done),
      .branch_taken_i  (branch_taken),
      .mem_req_i       (mem_req),
      .mem_ready_i     (mem_ready),
      .md_start_o      (md_start),
      .stall_if_o      (stall_if),
      .stall_id_o      (stall_id),
      .stall_ex_o      (stall_ex),
      .stall_mem_o     (stall_mem),
      .flush_id_o      (flush_id),
      .flush_ex_o      (flush_ex),
      .flush_mem_o     (flush_mem),
      .ignore_fwd_ex_o (ignore_fwd_ex),
      .stall_cycles_o  (stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {md_start, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem};
   endfunction

   task automatic set_in(input logic [RW-1:0] rs1, input logic u1, input logic [RW-1:0] rs2,
                         input logic u2, input logic ld, input logic [RW-1:0] rd,
                         input logic md, input logic dn, input logic br,
                         input logic mq, input logic mr);
      id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
      ex_mem_read = ld; ex_rd = rd; ex_is_muldiv = md; md_done = dn;
      branch_taken = br; mem_req = mq; mem_ready = mr;
   endtask

   // Inputs already applied; check comb outputs, clock once, check registered state.
   task automatic cycle(input string tag, input logic [7:0] exp_o, input logic exp_ign);
      #1;
      chk({tag, ".out"}, {24'd0, outs()}, {24'd0, exp_o});
      if (exp_o[6] && cnt_exp < 15) cnt_exp++;
      @(posedge clk); #1;
      chk({tag, ".ign"}, {31'd0, ignore_fwd_ex}, {31'd0, exp_ign});
      chk({tag, ".cnt"}, {28'd0, stall_cycles}, cnt_exp);
   endtask

   initial begin
      rst = 1'b1;
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      @(posedge clk); @(posedge clk); #2;
      chk("rst.out", {24'd0, outs()}, 32'd0);
      chk("rst.ign", {31'd0, ignore_fwd_ex}, 32'd0);
      chk("rst.cnt", {28'd0, stall_cycles}, 32'd0);
      rst = 1'b0;
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      cycle("idle", O_IDLE, 1'b0);

      // lw x5 in EX, add x6,x5,x1 in ID
      set_in(5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("lu_rs1", O_LU, 1'b1);
      set_in(5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("lu_bubble", O_IDLE, 1'b0);
      set_in(5'd9, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("lu_rs2", O_LU, 1'b1);
      set_in(5'd5, 1'b0, 5'd3, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("lu_nouse", O_IDLE, 1'b0);
      set_in(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("lu_x0", O_IDLE, 1'b0);
      set_in(5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cycle("br_lu", O_BR, 1'b1);

      // MUL/DIV: start, 4 wait cycles, done in 6th cycle; bubble tag held through stall
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("md_start", O_START, 1'b1);
      for (int i = 0; i < 4; i++) cycle("md_wait", O_MDW, 1'b1);
      md_done = 1'b1;
      cycle("md_done", O_IDLE, 1'b0);
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cycle("br2", O_BR, 1'b1);

      // MUL/DIV with a 3-cycle memory freeze, md_done in 2nd freeze cycle
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("mdm_start", O_START, 1'b1);
      cycle("mdm_wait", O_MDW, 1'b1);
      mem_req = 1'b1; mem_ready = 1'b0;
      cycle("mdm_frz1", O_FRZ, 1'b1);
      md_done = 1'b1;
      cycle("mdm_frz2", O_FRZ, 1'b1);
      md_done = 1'b0;
      cycle("mdm_frz3", O_FRZ, 1'b1);
      mem_ready = 1'b1;
      cycle("mdm_exit", O_IDLE, 1'b0);
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("mdm_after", O_IDLE, 1'b0);

      // MUL/DIV reaching EX during a freeze launches on the exit cycle
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("frz_md", O_FRZ, 1'b0);
      mem_ready = 1'b1;
      cycle("frz_md_exit", O_START, 1'b0);
      md_done = 1'b1; mem_req = 1'b0;
      cycle("frz_md_done", O_IDLE, 1'b0);

      // long freeze drives the 4-bit stall counter into saturation (20 stall cycles total)
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cycle("sat_frz", O_FRZ, 1'b0);
      chk("sat.cnt", {28'd0, stall_cycles}, 32'd15);
      mem_ready = 1'b1;
      cycle("sat_exit", O_IDLE, 1'b0);

      // async reset in the middle of MD_BUSY
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cycle("br3", O_BR, 1'b1);
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("rstmd_start", O_START, 1'b1);
      #1;
      chk("rstmd_busy.out", {24'd0, outs()}, {24'd0, O_MDW});
      md_done = 1'b1;
      rst = 1'b1;
      #1;
      chk("rstmd.out", {24'd0, outs()}, 32'd0);
      chk("rstmd.ign", {31'd0, ignore_fwd_ex}, 32'd0);
      chk("rstmd.cnt", {28'd0, stall_cycles}, 32'd0);
      cnt_exp = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      md_done = 1'b0;
      cycle("post_rst_start", O_START, 1'b0);
      cycle("post_rst_wait", O_MDW, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
